// File: rtl/count_seq_monitor.sv
// -----------------------------------------------------------------------------
// count_seq_monitor
//
// Receive-side checker for a 2-bit modulo-4 enable counter carried on a 3-bit
// bus. It samples the bus and the counter's enable every rising edge, predicts
// the next legal value, and reports illegal encodings (4..7) and sequence
// violations. It also tracks lock state and counts clean 3 -> 0 wraps.
//
// Parameters:
//   RESYNC_CNT : consecutive correct transitions needed in FAULT before the
//                monitor returns to SYNC (1..15)
//   WRAP_W     : width of the saturating wrap counter
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   en          in   counter enable (same signal the counter sees)
//   cnt_in      in   [2:0] counter output bus
//   clr         in   synchronous clear of sticky error state and wrap count
//   sync_out    out  1 while the monitor is locked (SYNC)
//   err_illegal out  one-cycle pulse: sample was 4..7
//   err_seq     out  one-cycle pulse: legal sample differed from prediction
//   err_sticky  out  set by any error, held until clr
//   err_code    out  [1:0] first error since clr: 01 illegal, 10 seq, 11 both
//   wrap_cnt    out  [WRAP_W-1:0] saturating count of clean 3 -> 0 in SYNC
// -----------------------------------------------------------------------------
module count_seq_monitor #(
    parameter int unsigned RESYNC_CNT = 4,
    parameter int unsigned WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        cnt_in,
    input  logic              clr,
    output logic              sync_out,
    output logic              err_illegal,
    output logic              err_seq,
    output logic              err_sticky,
    output logic [1:0]        err_code,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SYNC   = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_run;
    logic [3:0]  w_run_nxt;
    logic [4:0]  w_run_inc;

    // Reference model: last legal sample and the enable that accompanied it.
    logic [1:0]  r_ref_cnt;
    logic        r_ref_en;
    logic        r_ref_valid;

    logic        w_illegal;
    logic [1:0]  w_expected;
    logic        w_mismatch;
    logic        w_match;
    logic        w_ill_err;
    logic        w_seq_err;
    logic        w_any_err;
    logic [1:0]  w_code;
    logic        w_wrap_hit;

    // ------------------------------------------------------------------
    // Sample classification
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal  = cnt_in[2];
        w_expected = r_ref_en ? (r_ref_cnt + 2'd1) : r_ref_cnt;
        w_mismatch = !w_illegal && r_ref_valid && (cnt_in[1:0] != w_expected);
        w_match    = !w_illegal && r_ref_valid && !w_mismatch;
        w_run_inc  = {1'b0, r_run} + 5'd1;
    end

    // ------------------------------------------------------------------
    // Lock state machine: next state, run counter and error strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_ill_err   = 1'b0;
        w_seq_err   = 1'b0;
        w_wrap_hit  = 1'b0;

        case (r_state)
            ST_UNSYNC: begin
                // The first legal sample only seeds the reference; it is
                // never compared, so lock is taken without any check.
                if (w_illegal) begin
                    w_ill_err = 1'b1;
                end else begin
                    w_state_nxt = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (w_illegal) begin
                    w_ill_err   = 1'b1;
                    w_state_nxt = ST_FAULT;
                    w_run_nxt   = '0;
                end else if (w_mismatch) begin
                    w_seq_err   = 1'b1;
                    w_state_nxt = ST_FAULT;
                    w_run_nxt   = '0;
                end else if (w_match) begin
                    w_wrap_hit = (r_ref_cnt == 2'd3) && r_ref_en &&
                                 (cnt_in == 3'd0);
                end
            end

            ST_FAULT: begin
                if (w_illegal) begin
                    w_ill_err = 1'b1;
                    w_run_nxt = '0;
                end else if (w_mismatch) begin
                    w_seq_err = 1'b1;
                    w_run_nxt = '0;
                end else if (w_match) begin
                    if (w_run_inc == 5'(RESYNC_CNT)) begin
                        w_state_nxt = ST_SYNC;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = w_run_inc[3:0];
                    end
                end
                // A legal sample with no valid reference leaves run alone.
            end

            default: begin
                w_state_nxt = ST_UNSYNC;
                w_run_nxt   = '0;
            end
        endcase

        w_any_err = w_ill_err | w_seq_err;
        w_code    = {w_seq_err, w_ill_err};
    end

    // ------------------------------------------------------------------
    // State, run counter and reference registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_UNSYNC;
            r_run       <= '0;
            r_ref_cnt   <= '0;
            r_ref_en    <= 1'b0;
            r_ref_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            if (w_illegal) begin
                r_ref_valid <= 1'b0;
            end else begin
                r_ref_cnt   <= cnt_in[1:0];
                r_ref_en    <= en;
                r_ref_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered error pulses, sticky error state and wrap counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_sticky  <= 1'b0;
            err_code    <= '0;
            wrap_cnt    <= '0;
        end else begin
            err_illegal <= w_ill_err;
            err_seq     <= w_seq_err;

            // An error in the same cycle as clr takes precedence: the clear
            // is applied and this cycle's error becomes the new first error.
            if (w_any_err) begin
                err_sticky <= 1'b1;
                if (clr || (err_code == 2'b00)) begin
                    err_code <= w_code;
                end
            end else if (clr) begin
                err_sticky <= 1'b0;
                err_code   <= '0;
            end

            if (clr) begin
                wrap_cnt <= '0;
            end else if (w_wrap_hit && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + 1'b1;
            end
        end
    end

    assign sync_out = (r_state == ST_SYNC);

endmodule

// File: tb/tb_count_seq_monitor.sv
module tb_count_seq_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] cnt_in;
    logic       clr;

    logic       sync_out, err_illegal, err_seq, err_sticky;
    logic [1:0] err_code;
    logic [7:0] wrap_cnt;

    logic       sync_out2, err_illegal2, err_seq2, err_sticky2;
    logic [1:0] err_code2;
    logic [1:0] wrap_cnt2;

    int checks = 0;
    int errors = 0;

    count_seq_monitor #(.RESYNC_CNT(4), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr(clr),
        .sync_out(sync_out), .err_illegal(err_illegal), .err_seq(err_seq),
        .err_sticky(err_sticky), .err_code(err_code), .wrap_cnt(wrap_cnt)
    );

    count_seq_monitor #(.RESYNC_CNT(4), .WRAP_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr(clr),
        .sync_out(sync_out2), .err_illegal(err_illegal2), .err_seq(err_seq2),
        .err_sticky(err_sticky2), .err_code(err_code2), .wrap_cnt(wrap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s, input logic ill,
                           input logic seq, input logic stk, input logic [1:0] code,
                           input logic [7:0] wrap);
        chk({tag, ".sync"},   {7'd0, sync_out},    {7'd0, s});
        chk({tag, ".ill"},    {7'd0, err_illegal}, {7'd0, ill});
        chk({tag, ".seq"},    {7'd0, err_seq},     {7'd0, seq});
        chk({tag, ".sticky"}, {7'd0, err_sticky},  {7'd0, stk});
        chk({tag, ".code"},   {6'd0, err_code},    {6'd0, code});
        chk({tag, ".wrap"},   wrap_cnt,            wrap);
    endtask

    // Drive one sample on the falling edge, let the rising edge take it,
    // then settle before the caller checks.
    task automatic step(input logic [2:0] c, input logic e, input logic k);
        @(negedge clk);
        cnt_in = c;
        en     = e;
        clr    = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cnt_in = 3'd0; clr = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 2'b00, 8'd0);
        chk("reset.wrap2", {6'd0, wrap_cnt2}, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: lock and first wrap
        step(3'd0, 1, 0);
        chk_all("t1.lock", 1, 0, 0, 0, 2'b00, 8'd0);
        step(3'd1, 1, 0);
        step(3'd2, 1, 0);
        step(3'd3, 1, 0);
        chk_all("t1.at3", 1, 0, 0, 0, 2'b00, 8'd0);
        step(3'd0, 1, 0);
        chk_all("t1.wrap", 1, 0, 0, 0, 2'b00, 8'd1);
        step(3'd1, 1, 0);
        chk_all("t1.after", 1, 0, 0, 0, 2'b00, 8'd1);

        // 2: hold at 2, then illegal change while disabled
        step(3'd2, 0, 0);
        step(3'd2, 0, 0);
        step(3'd2, 0, 0);
        step(3'd2, 0, 0);
        chk_all("t2.hold", 1, 0, 0, 0, 2'b00, 8'd1);
        step(3'd3, 0, 0);
        chk_all("t2.seqerr", 0, 0, 1, 1, 2'b10, 8'd1);
        step(3'd3, 0, 0);
        chk_all("t2.pulse", 0, 0, 0, 1, 2'b10, 8'd1);
        step(3'd3, 1, 0);
        step(3'd0, 1, 0);
        chk_all("t2.run3", 0, 0, 0, 1, 2'b10, 8'd1);
        step(3'd1, 1, 0);
        chk_all("t2.relock", 1, 0, 0, 1, 2'b10, 8'd1);

        // 3: illegal value, uncompared sample, resync after 4 matches
        step(3'd2, 1, 1);
        chk_all("t3.clr", 1, 0, 0, 0, 2'b00, 8'd0);
        step(3'd5, 1, 0);
        chk_all("t3.illegal", 0, 1, 0, 1, 2'b01, 8'd0);
        step(3'd1, 1, 0);
        chk_all("t3.nocmp", 0, 0, 0, 1, 2'b01, 8'd0);
        step(3'd2, 1, 0);
        step(3'd3, 1, 0);
        step(3'd0, 1, 0);
        chk_all("t3.run3", 0, 0, 0, 1, 2'b01, 8'd0);
        step(3'd1, 1, 0);
        chk_all("t3.resync", 1, 0, 0, 1, 2'b01, 8'd0);

        // 4: skip, skip during FAULT resets run, clr alone, clr with error
        step(3'd2, 1, 1);
        step(3'd0, 1, 0);
        chk_all("t4.skip", 0, 0, 1, 1, 2'b10, 8'd0);
        step(3'd1, 1, 0);
        step(3'd2, 1, 0);
        step(3'd0, 1, 0);
        chk_all("t4.faultskip", 0, 0, 1, 1, 2'b10, 8'd0);
        step(3'd1, 1, 0);
        step(3'd2, 1, 0);
        step(3'd3, 1, 0);
        chk_all("t4.run3", 0, 0, 0, 1, 2'b10, 8'd0);
        step(3'd0, 1, 0);
        chk_all("t4.resync", 1, 0, 0, 1, 2'b10, 8'd0);
        step(3'd1, 1, 1);
        chk_all("t4.clr", 1, 0, 0, 0, 2'b00, 8'd0);
        step(3'd6, 1, 1);
        chk_all("t4.clr_err", 0, 1, 0, 1, 2'b01, 8'd0);
        step(3'd0, 1, 0);
        step(3'd1, 1, 0);
        step(3'd2, 1, 0);
        step(3'd3, 1, 0);
        step(3'd0, 1, 0);
        chk_all("t4.relock", 1, 0, 0, 1, 2'b01, 8'd0);

        // 5: saturating wrap counter on the narrow instance
        step(3'd1, 1, 1);
        chk("t5.clr.wrap2", {6'd0, wrap_cnt2}, 8'd0);
        for (int w = 1; w <= 5; w++) begin
            if (w > 1) step(3'd1, 1, 0);
            step(3'd2, 1, 0);
            step(3'd3, 1, 0);
            step(3'd0, 1, 0);
            chk($sformatf("t5.wrap2_%0d", w), {6'd0, wrap_cnt2}, (w < 3) ? 8'(w) : 8'd3);
            chk($sformatf("t5.wrap8_%0d", w), wrap_cnt, 8'(w));
        end
        chk("t5.sync2", {7'd0, sync_out2}, 8'd1);
        chk_all("t5.end", 1, 0, 0, 0, 2'b00, 8'd5);

        // 6: asynchronous reset mid-stream, relock without an error
        step(3'd1, 1, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all("t6.async", 0, 0, 0, 0, 2'b00, 8'd0);
        chk("t6.dut2", {1'b0, sync_out2, err_illegal2, err_seq2, err_sticky2, err_code2, wrap_cnt2 != 2'd0}, 8'd0);
        cnt_in = 3'd2;
        en     = 1'b1;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("t6.relock", 1, 0, 0, 0, 2'b00, 8'd0);
        step(3'd3, 1, 0);
        chk_all("t6.next", 1, 0, 0, 0, 2'b00, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Receive-side checker for the 2-bit modulo-4 enable counter's 3-bit output bus (legal values 0..3).
- Samples the count bus and the same enable that drives the counter each cycle, and verifies the count follows the legal progression.
- Flags illegal encodings and sequence violations, tracks lock state, and counts observed wraps (3 -> 0).
- Sits beside the counter in the same clock domain; outputs feed error aggregation and test logic.

Parameters:
RESYNC_CNT, 4, consecutive correct transitions required in FAULT before re-entering SYNC (range 1..15)
WRAP_W, 8, width of wrap counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
en  input  1  counter enable, same signal the counter sees
cnt_in  input  3  counter output bus
clr  input  1  synchronous clear of sticky error state and wrap count
sync_out  output  1  1 = monitor locked (state SYNC)
err_illegal  output  1  one-cycle pulse: cnt_in sample was 4..7
err_seq  output  1  one-cycle pulse: legal sample differs from expected
err_sticky  output  1  set by any error, held until clr
err_code  output  2  first-error code since last clr: 00 none, 01 illegal, 10 sequence, 11 both in same cycle
wrap_cnt  output  WRAP_W  saturating count of correct 3 -> 0 transitions seen while in SYNC

Behaviour:
- Reset (rst=0, async): state UNSYNC, ref_valid=0, run=0; all outputs 0, wrap_cnt=0.
- Reference model: registers ref_cnt[1:0], ref_en, ref_valid.
  - expected = ref_en ? (ref_cnt+1) mod 4 : ref_cnt.
  - Every legal sample loads ref_cnt=cnt_in[1:0], ref_en=en, ref_valid=1.
  - An illegal sample clears ref_valid.
- Sample evaluation each rising edge (all outputs registered; one cycle latency from sample to flag):
  - illegal = cnt_in[2].
  - mismatch = !illegal & ref_valid & (cnt_in[1:0] != expected).
  - match = !illegal & ref_valid & !mismatch.
  - A sample with ref_valid=0 is never compared: no err_seq, no run change.
- State machine:
  - UNSYNC: first legal sample -> SYNC, with no comparison. Illegal sample -> pulse err_illegal, stay in UNSYNC.
  - SYNC: match -> stay. Mismatch -> pulse err_seq, go to FAULT, run=0. Illegal -> pulse err_illegal, go to FAULT, run=0.
  - FAULT:
    - Match -> run+1; when run+1 == RESYNC_CNT, go to SYNC and run=0.
    - Mismatch -> pulse err_seq, run=0.
    - Illegal -> pulse err_illegal, run=0.
    - Non-compared legal sample -> no change to run.
- sync_out = 1 exactly when state == SYNC.
- wrap_cnt: increments on a match in SYNC where ref_cnt==3, ref_en==1, cnt_in==0. Saturates at 2^WRAP_W-1; never wraps.
- Sticky errors:
  - Any error pulse sets err_sticky.
  - err_code is loaded only when it is currently 00 (first error wins).
  - clr zeroes err_sticky, err_code and wrap_cnt.
  - clr in the same cycle as an error: the error wins. err_sticky=1, err_code = that cycle's code, wrap_cnt=0.
- clr has no effect on state, run or the reference registers.
- en=0 with cnt_in unchanged is legal (hold). en=1 requires increment; 3 -> 0 is the legal wrap.
- Reset mid-operation: immediate return to reset values. The first legal sample after release re-locks without flagging.

Test Plan:
1. Release reset; en=1; cnt_in 0,1,2,3,0,1 on successive edges -> sync_out=1 the cycle after the first sample; err_* stay 0; wrap_cnt=1 after the 3 -> 0 sample.
2. Locked at cnt=2: en=0 for 3 cycles with cnt_in=2 -> no errors. Then en=0 with cnt_in changed to 3 -> err_seq one-cycle pulse, err_code=10, sync_out=0.
3. Locked; cnt_in=5 -> err_illegal pulse, err_code=01, err_sticky=1, FAULT. Next sample 1 is not compared. Then with en=1, samples 2,3,0,1 -> sync_out=1 after the 4th match (RESYNC_CNT=4). In FAULT, a skip after 2 matches resets run, so 4 further matches are needed.
4. Locked; skip 1 -> 3 -> err_seq, err_code=10. Assert clr alone -> err_code=00, err_sticky=0, wrap_cnt=0. Inject an illegal value with clr=1 on the same edge -> err_code=01, err_sticky=1.
5. WRAP_W=2; 5 clean wraps in SYNC -> wrap_cnt reads 1,2,3,3,3.
6. Locked mid-stream; pulse rst=0 between edges -> all outputs 0 immediately (asynchronous). After release, first sample 2 with no prior reference -> no error, sync_out=1 the next cycle.
